// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_unit: iterative RV32M multiply/divide, radix-2, 34-cycle latency     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      ALUOp,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  op_q, op_d;
  logic        neg_prod_q, neg_prod_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;
  logic        result_valid_q, result_valid_d;

  logic        is_md, is_div, is_rem, accept;
  logic        a_neg, b_neg, div0, ovf;
  logic [31:0] a_mag, b_mag;

  assign is_md  = (ALUOp[4:3] == 2'b10);
  assign is_div = ALUOp[2];
  assign is_rem = ALUOp[2] & ALUOp[1];
  assign a_neg  = op_a[31] & ((ALUOp == OP_MULH) | (ALUOp == OP_MULHSU) |
                              (ALUOp == OP_DIV)  | (ALUOp == OP_REM));
  assign b_neg  = op_b[31] & ((ALUOp == OP_MULH) | (ALUOp == OP_DIV) | (ALUOp == OP_REM));
  assign a_mag  = a_neg ? -op_a : op_a;
  assign b_mag  = b_neg ? -op_b : op_b;
  assign div0   = is_div & (op_b == 32'd0);
  assign ovf    = ((ALUOp == OP_DIV) | (ALUOp == OP_REM)) &
                  (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
  assign accept = (state_q == S_IDLE) & start & is_md & ~flush;

  assign stall = accept | (state_q == S_MUL) | (state_q == S_DIV) | (state_q == S_FIX);
  assign result       = result_q;
  assign result_valid = result_valid_q;

  // Multiply: high half accumulates, multiplier shifts out of the low half.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? a_q : 32'd0)};
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Divide: high half is the remainder, low half shifts dividend out / quotient in.
  logic [32:0] div_shift;
  logic [31:0] div_sub, rem_new;
  logic        div_ge;
  logic [63:0] div_next;
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_sub   = div_shift[31:0] - b_q;
  assign rem_new   = div_ge ? div_sub : div_shift[31:0];
  assign div_next  = {rem_new, acc_q[30:0], div_ge};

  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_res;
  assign prod_fix = neg_prod_q ? -acc_q : acc_q;
  assign quo_fix  = neg_prod_q ? -acc_q[31:0] : acc_q[31:0];
  assign rem_fix  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];

  always_comb begin
    fix_res = prod_fix[63:32];
    case (op_q)
      OP_MUL:           fix_res = prod_fix[31:0];
      OP_DIV, OP_DIVU:  fix_res = quo_fix;
      OP_REM, OP_REMU:  fix_res = rem_fix;
      default:          fix_res = prod_fix[63:32];
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    neg_prod_d     = neg_prod_q;
    neg_rem_d      = neg_rem_q;
    a_d            = a_q;
    b_d            = b_q;
    acc_d          = acc_q;
    result_d       = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d       = ALUOp;
          neg_prod_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          a_d        = a_mag;
          b_d        = b_mag;
          if (div0) begin
            result_d = is_rem ? op_a : 32'hFFFF_FFFF;
            state_d  = S_DONE;
          end else if (ovf) begin
            result_d = is_rem ? 32'd0 : 32'h8000_0000;
            state_d  = S_DONE;
          end else begin
            cnt_d   = 5'd31;
            acc_d   = {32'd0, (is_div ? a_mag : b_mag)};
            state_d = is_div ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        if (cnt_q == 5'd0) state_d = S_FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      S_DIV: begin
        acc_d = div_next;
        if (cnt_q == 5'd0) state_d = S_FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
    result_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= 5'd0;
      op_q           <= 5'd0;
      neg_prod_q     <= 1'b0;
      neg_rem_q      <= 1'b0;
      a_q            <= 32'd0;
      b_q            <= 32'd0;
      acc_q          <= 64'd0;
      result_q       <= 32'd0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      neg_prod_q     <= neg_prod_d;
      neg_rem_q      <= neg_rem_d;
      a_q            <= a_d;
      b_q            <= b_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_muldiv_unit: directed self-checking bench for muldiv_unit               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_muldiv_unit;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  ALUOp = 5'd0;
  logic [31:0] op_a  = 32'd0;
  logic [31:0] op_b  = 32'd0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .ALUOp        (ALUOp),
    .op_a         (op_a),
    .op_b         (op_b),
    .flush        (flush),
    .stall        (stall),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts in an idle cycle just after a rising edge; returns in the idle cycle after DONE.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input string tag);
    int lat;
    int drops;
    lat   = -1;
    drops = 0;
    ALUOp = op; op_a = a; op_b = b; start = 1'b1;
    #1;
    chk({tag, "_stall_c0"}, 32'(stall), 32'd1);
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clock); #1;
      start = 1'b0; ALUOp = OP_MUL; op_a = ~a; op_b = a ^ b;
      #1;
      if (result_valid) begin
        lat = c;
        chk({tag, "_stall_done"}, 32'(stall), 32'd0);
        chk({tag, "_result"}, result, exp_res);
      end else if (!stall) begin
        drops++;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_stall_drops"}, 32'(drops), 32'd0);
    @(posedge clock); #1;
    chk({tag, "_pulse_width"}, 32'(result_valid), 32'd0);
    chk({tag, "_result_held"}, result, exp_res);
  endtask

  initial begin
    int seen;

    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    #10 reset = 1'b1;
    @(posedge clock); #1;

    run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul");

    // Flush in cycle 10 of a MUL: back to idle, no pulse, result untouched.
    ALUOp = OP_MUL; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    #1;
    chk("fl_stall_c0", 32'(stall), 32'd1);
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (c == 10) flush = 1'b1;
      #1;
      if (result_valid) seen++;
    end
    @(posedge clock); #1;
    flush = 1'b0;
    #1;
    chk("fl_idle_stall", 32'(stall), 32'd0);
    chk("fl_valid", 32'(result_valid), 32'd0);
    chk("fl_result", result, 32'hFFFF_FFEB);
    chk("fl_no_pulse", 32'(seen), 32'd0);
    run_op(OP_MUL, 32'd6, 32'd7, 32'd42, 34, "mul_after_flush");

    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh");
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, "mulhsu");
    run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div");
    run_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem");
    run_op(OP_DIVU,   32'd100,       32'd7,         32'd14,        34, "divu");
    run_op(OP_REMU,   32'd100,       32'd7,         32'd2,         34, "remu");

    // Flush in idle must block acceptance.
    ALUOp = OP_MUL; op_a = 32'd9; op_b = 32'd9; start = 1'b1; flush = 1'b1;
    #1;
    chk("fl_idle_block_stall", 32'(stall), 32'd0);
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    chk("fl_idle_block_state", 32'(stall), 32'd0);
    chk("fl_idle_block_valid", 32'(result_valid), 32'd0);

    // Non-M op is ignored.
    ALUOp = OP_ADD; op_a = 32'd1; op_b = 32'd2; start = 1'b1;
    #1;
    chk("add_stall", 32'(stall), 32'd0);
    seen = 0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clock); #1;
      if (result_valid || stall) seen++;
    end
    start = 1'b0;
    chk("add_ignored", 32'(seen), 32'd0);

    // Reset asserted in cycle 20 of a DIV.
    ALUOp = OP_DIV; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    #1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #1;
      start = 1'b0;
    end
    #1;
    chk("rstmid_stall_before", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("rstmid_stall", 32'(stall), 32'd0);
    chk("rstmid_result", result, 32'd0);
    chk("rstmid_valid", 32'(result_valid), 32'd0);
    #2 reset = 1'b1;
    @(posedge clock); #1;
    chk("rstmid_idle_stall", 32'(stall), 32'd0);
    chk("rstmid_idle_valid", 32'(result_valid), 32'd0);
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu_after_rst");

    run_op(OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "divu_by0");
    run_op(OP_REM,  32'd5,         32'd0,         32'd5,         1, "rem_by0");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit in the EX stage. It consumes the 5-bit ALU operation code produced by the EX-stage ALU control decode, together with the forwarded operands, and executes the RV32M operations over multiple cycles. While an operation is in flight it holds `stall` high to freeze the pipeline. It then presents the 32-bit result for one cycle with `result_valid`. Single-cycle ALU ops never enter this block.

## Interface

- `XLEN`, 32: operand/result width; only 32 is supported.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  EX holds a valid instruction; acted on only when `ALUOp` is an M-extension code.
- `ALUOp`  in  5  operation code: `MUL`, `MULH`, `MULHSU`, `MULHU`, `DIV`, `DIVU`, `REM`, `REMU` from constants.vh.
- `op_a`  in  XLEN  rs1 value after forwarding.
- `op_b`  in  XLEN  rs2 value after forwarding.
- `flush`  in  1  kill the in-flight operation (branch mispredict or exception).
- `stall`  out  1  pipeline freeze request.
- `result`  out  XLEN  final result; held until the next accepted start.
- `result_valid`  out  1  one-cycle pulse when `result` is final.

## Operation

- `is_md` is high when `ALUOp` is one of the 8 M codes. `start` with `is_md` low is ignored.
- States:
  - IDLE
  - MUL: 32 iterations
  - DIV: 32 iterations
  - FIX: sign correction
  - DONE
- Accept rule: in IDLE, `start & is_md & !flush` latches `ALUOp`, `op_a`, `op_b` and decodes signedness:
  - signed a: MULH, MULHSU, DIV, REM
  - signed b: MULH, DIV, REM
- Operand preparation: operands marked signed are converted to magnitudes (two's-complement negate if bit 31 is set). Store `neg_prod = sa ^ sb` and `neg_rem = sa`.
- MUL: unsigned radix-2 shift-add over a 64-bit accumulator, 5-bit counter 31 down to 0, one bit per cycle. At count 0 go to FIX.
- DIV: restoring division on magnitudes, one quotient bit per cycle, 33-bit partial remainder. At count 0 go to FIX.
- FIX:
  - MUL family: negate the 64-bit product if `neg_prod`.
  - DIV/DIVU: negate the quotient if `neg_prod`.
  - REM/REMU: negate the remainder if `neg_rem`.
  - Select the result: MUL takes bits [31:0]; MULH, MULHSU and MULHU take bits [63:32].
  - Register `result`, then go to DONE.
- Fast path (IDLE→DONE directly, `result` registered on the accept edge):
  - divisor == 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `op_a`.
  - DIV/REM with `op_a` = 0x80000000 and `op_b` = 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- DONE: `result_valid` = 1 for exactly one cycle, then IDLE. A new start is accepted in the cycle after DONE, not in DONE itself.
- `flush`: from any state the next state is IDLE and no `result_valid` is produced. `result` keeps its prior value. `flush` in IDLE blocks acceptance. `flush` during DONE does not suppress the already-asserted pulse.
- Reset (asserted at any time, including mid-operation):
  - state IDLE, counter 0
  - `result` 0, `result_valid` 0
  - all internal registers 0
  - `stall` 0

## Timing

- `stall` is combinational: `(IDLE & start & is_md & !flush) | MUL | DIV | FIX`. It is 0 in DONE, so the pipeline advances in the DONE cycle and captures `result`.
- Normal latency, with the accept cycle as cycle 0:
  - cycles 1–32: MUL or DIV
  - cycle 33: FIX
  - cycle 34: DONE, `result_valid` = 1
- `stall` is high in cycles 0–33.
- Fast-path latency: `stall` is high in cycle 0, then DONE and `result_valid` in cycle 1.
- Operands are sampled only at the accept edge. Changes on `op_a`, `op_b` or `ALUOp` afterwards have no effect.
- `result` changes only on the FIX→DONE edge, the fast-path accept edge, and reset.

## Test plan

- MUL 7 × 0xFFFFFFFD → `result` 0xFFFFFFEB, `result_valid` at cycle 34, `stall` high cycles 0–33 and low at cycle 34.
- High-word products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF
- Signed division: DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD, and REM of the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14, and REMU → 2.
- Fast path:
  - DIVU 5 / 0 → 0xFFFFFFFF at cycle 1
  - REM 5 / 0 → 5
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000
  - REM of the same operands → 0
- Flush during MUL at cycle 10 → IDLE at cycle 11, no `result_valid`, `result` unchanged. A new start at cycle 11 is accepted and completes normally.
- Other sequences:
  - `reset` pulled low at cycle 20 of a DIV → `stall`, `result` and `result_valid` all 0 immediately; after release the unit is idle.
  - `start` with ALUOp `ADD` → no `stall`, no `result_valid`.
